// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, mux codes and the
// control vector produced by the output decoder.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBRt     = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(logic [5:0] op, bit en_addi, bit en_jump, bit en_bne);
        case (op)
            OpRtype, OpLw, OpSw, OpBeq: return 1'b1;
            OpAddi:                     return en_addi;
            OpJ:                        return en_jump;
            OpBne:                      return en_bne;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. The controller is the master; the datapath (or bench)
// supplies opcode, zero flag and memory-ready as the slave.
interface multicycle_ctrl_if #(
    parameter int unsigned ALUOP_W = 2
) ();
    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               iord;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               pc_en;
    logic               illegal_op;
    logic [3:0]         state;

    modport master (
        input  op, zero, mem_ready,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_src, pc_en, illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_src, pc_en, illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// Moore output decode: current state (plus zero / mem-ready where they qualify an enable)
// to the datapath control vector. Purely combinational.
module multicycle_ctrl_outdec
    import multicycle_ctrl_pkg::*;
#(
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1,
    parameter bit EN_BNE  = 1'b0
) (
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    input  logic       bne_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_en     = mem_ready_i;
            end
            StDecode: begin
                ctrl_o.alu_src_b  = SrcBImmSh2;
                ctrl_o.illegal_op = !op_legal(op_i, EN_ADDI, EN_JUMP, EN_BNE);
            end
            StMemAdr: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
            end
            StMemRd: ctrl_o.iord = 1'b1;
            StMemWb: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            StMemWr: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = AluOpSub;
                ctrl_o.pc_src    = PcSrcAluOut;
                // bne_i only ever set when BNE is enabled.
                ctrl_o.pc_en     = bne_i ? !zero_i : zero_i;
            end
            StAddiEx: begin
                if (EN_ADDI) begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SrcBImm;
                end
            end
            StAddiWb: ctrl_o.reg_write = EN_ADDI;
            StJump: begin
                if (EN_JUMP) begin
                    ctrl_o.pc_src = PcSrcJump;
                    ctrl_o.pc_en  = 1'b1;
                end
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: state register and next-state logic; the Moore output
// decode lives in multicycle_ctrl_outdec.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 2,
    parameter bit          EN_ADDI = 1'b1,
    parameter bit          EN_JUMP = 1'b1,
    parameter bit          EN_BNE  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_e state_q, state_d;
    logic   bne_q, bne_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = StFetch;
        // Remember BEQ vs BNE at decode so the branch state never looks at the opcode.
        bne_d   = (state_q == StDecode) ? (EN_BNE && bus.op == OpBne) : bne_q;
        case (state_q)
            StFetch: state_d = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (op_legal(bus.op, EN_ADDI, EN_JUMP, EN_BNE)) begin
                    case (bus.op)
                        OpLw, OpSw:   state_d = StMemAdr;
                        OpRtype:      state_d = StExec;
                        OpBeq, OpBne: state_d = StBranch;
                        OpAddi:       state_d = StAddiEx;
                        OpJ:          state_d = StJump;
                        default:      state_d = StFetch;
                    endcase
                end
            end
            StMemAdr: begin
                if (bus.op == OpLw) begin
                    state_d = StMemRd;
                end else if (bus.op == OpSw) begin
                    state_d = StMemWr;
                end
            end
            StMemRd:  state_d = bus.mem_ready ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = bus.mem_ready ? StFetch : StMemWr;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StAddiEx: state_d = EN_ADDI ? StAddiWb : StFetch;
            StAddiWb: state_d = StFetch;
            StJump:   state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bne_q   <= bne_d;
        end
    end

    multicycle_ctrl_outdec #(
        .EN_ADDI (EN_ADDI),
        .EN_JUMP (EN_JUMP),
        .EN_BNE  (EN_BNE)
    ) u_outdec (
        .state_i     (state_q),
        .op_i        (bus.op),
        .zero_i      (bus.zero),
        .mem_ready_i (bus.mem_ready),
        .bne_i       (bne_q),
        .ctrl_o      (ctrl)
    );

    // Reset holds FETCH, whose IRWrite/PcEn follow MemReady; gate every enable explicitly.
    assign bus.ir_write   = ctrl.ir_write & rst_n;
    assign bus.pc_en      = ctrl.pc_en & rst_n;
    assign bus.mem_write  = ctrl.mem_write & rst_n;
    assign bus.reg_write  = ctrl.reg_write & rst_n;
    assign bus.iord       = ctrl.iord;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ALUOP_W'(ctrl.alu_op);
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.state      = state_q;

endmodule
